// File: rtl/spi_byte_master.sv
// spi_byte_master
// SPI mode-0 master byte engine. Accepts bytes on a valid/ready handshake,
// shifts them out MSB-first on mosi_o while sampling miso_i on each SCK rise,
// and returns the received byte with a one-cycle rx_valid pulse. tx_last
// decides whether chip select is released after the byte or held low so that
// several bytes form one SPI transaction.
module spi_byte_master #(
    parameter int DIV = 4   // SCK half-period in clk cycles, 1..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       sck_o,
    output logic       mosi_o,
    input  logic       miso_i,
    output logic       cs_n_o
);

    typedef enum logic [2:0] {
        S_IDLE,   // CS high, waiting for a byte
        S_SETUP,  // CS low, MSB presented, SCK low before first rise
        S_HIGH,   // SCK high phase
        S_LOW,    // SCK low phase
        S_OPEN,   // CS still low, waiting for the next byte of the frame
        S_HOLD    // CS low, SCK low, trailing delay before CS release
    } state_t;

    // Divider compare value; the counter runs 0..DIV-1 so 8 bits cover DIV=255.
    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    state_t     r_state;
    logic [7:0] r_div;
    logic [6:0] r_tx_sh;     // bits still to be sent after the one on mosi_o
    logic [7:0] r_rx_sh;
    logic [3:0] r_bit_cnt;   // number of SCK rises in the current byte
    logic       r_last;

    logic       w_div_exp;
    logic       w_accept;
    logic       w_sck_rise;
    logic       w_byte_done;

    assign tx_ready    = (r_state == S_IDLE) || (r_state == S_OPEN);
    assign busy        = (r_state != S_IDLE);
    assign w_accept    = tx_valid && tx_ready;
    assign w_div_exp   = (r_div == DIV_LAST);

    // The byte ends when the low phase after the 8th rise expires.
    assign w_byte_done = w_div_exp && (r_state == S_LOW) && (r_bit_cnt == 4'd8);

    // An SCK rise happens when SETUP or a non-final LOW phase expires.
    assign w_sck_rise  = w_div_exp &&
                         ((r_state == S_SETUP) ||
                          ((r_state == S_LOW) && (r_bit_cnt != 4'd8)));

    // Phase divider: held at zero while waiting, restarts on every phase change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (tx_ready || w_div_exp) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 8'd1;
        end
    end

    // Receive shift and bit count advance on each SCK rise; count clears per byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sh   <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_bit_cnt <= '0;
        end else if (w_sck_rise) begin
            r_rx_sh   <= {r_rx_sh[6:0], miso_i};
            r_bit_cnt <= r_bit_cnt + 4'd1;
        end
    end

    // Sequencer: phase transitions, transmit shifting and all registered SPI outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_tx_sh  <= '0;
            r_last   <= 1'b0;
            sck_o    <= 1'b0;
            mosi_o   <= 1'b0;
            cs_n_o   <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_OPEN: begin
                    if (w_accept) begin
                        r_state <= S_SETUP;
                        r_tx_sh <= tx_data[6:0];
                        r_last  <= tx_last;
                        mosi_o  <= tx_data[7];
                        cs_n_o  <= 1'b0;
                        sck_o   <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (w_sck_rise) begin
                        r_state <= S_HIGH;
                        sck_o   <= 1'b1;
                    end
                end
                S_HIGH: begin
                    // Falling edge: present the next bit; after bit 0 a zero shifts in.
                    if (w_div_exp) begin
                        r_state <= S_LOW;
                        sck_o   <= 1'b0;
                        mosi_o  <= r_tx_sh[6];
                        r_tx_sh <= {r_tx_sh[5:0], 1'b0};
                    end
                end
                S_LOW: begin
                    if (w_byte_done) begin
                        rx_data  <= r_rx_sh;
                        rx_valid <= 1'b1;
                        mosi_o   <= 1'b0;
                        r_state  <= r_last ? S_HOLD : S_OPEN;
                    end else if (w_sck_rise) begin
                        r_state <= S_HIGH;
                        sck_o   <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_div_exp) begin
                        r_state <= S_IDLE;
                        cs_n_o  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    sck_o   <= 1'b0;
                    mosi_o  <= 1'b0;
                    cs_n_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule
